// File: rtl/jtroadf_objbuf_if.sv
// ---------------------------------------------------------------------------
// jtroadf_objbuf_if
// Handshake and pixel-write bus between the object drawer and the object
// line buffer.
//
//   draw_start : buffer -> drawer, one-clk pulse to begin drawing a line
//   draw_busy  : buffer -> drawer, high while the write bank accepts pixels
//   draw_done  : drawer -> buffer, drawer finished the current line
//   wr_en      : drawer -> buffer, pixel write strobe
//   wr_x       : drawer -> buffer, write column (0..255)
//   wr_pxl     : drawer -> buffer, pixel value (0 = transparent)
//
// Modports: master = drawer side, slave = line buffer side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface jtroadf_objbuf_if #(
    parameter int PW = 4
);
    logic          draw_start;
    logic          draw_busy;
    logic          draw_done;
    logic          wr_en;
    logic [7:0]    wr_x;
    logic [PW-1:0] wr_pxl;

    modport master (
        input  draw_start, draw_busy,
        output draw_done, wr_en, wr_x, wr_pxl
    );

    modport slave (
        output draw_start, draw_busy,
        input  draw_done, wr_en, wr_x, wr_pxl
    );
endinterface

// File: rtl/jtroadf_objbuf.sv
// ---------------------------------------------------------------------------
// jtroadf_objbuf
// Double-buffered object line buffer. The drawer fills one 256-entry bank
// while the other bank is scanned out to the colour mixer. Each scanned
// entry is cleared right after it is read, so a bank is blank again by the
// time it becomes the write bank.
//
// Parameters
//   PW  : pixel width in bits
//   DLY : output latency in pxl_cen ticks (only 1 is supported)
//
// Ports
//   clk      : system clock (48 MHz), the only clock
//   rst      : synchronous active-high reset; restarts the clear sweep
//   pxl_cen  : pixel clock enable for the read side
//   hinit    : line-start pulse, swaps banks and starts the drawer
//   LHBL     : horizontal blank, active low
//   flip     : screen flip, mirrors the read address
//   hdump    : horizontal pixel counter (only [7:0] is used)
//   drw      : drawer handshake / pixel-write bus (slave side)
//   overrun  : sticky, set when a line swap hits an unfinished drawing
//   pxl      : object pixel to the colour mixer
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module jtroadf_objbuf #(
    parameter int PW  = 4,
    parameter int DLY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            hinit,
    input  logic            LHBL,
    input  logic            flip,
    input  logic [8:0]      hdump,
    jtroadf_objbuf_if.slave drw,
    output logic            overrun,
    output logic [PW-1:0]   pxl
);

    typedef enum logic [1:0] {
        CLR  = 2'd0,
        IDLE = 2'd1,
        DRAW = 2'd2
    } state_e;

    state_e        state_q;
    logic [7:0]    cnt_q;
    logic          sel_q;        // read bank; the write bank is ~sel_q
    logic          draw_start_q;
    logic          overrun_q;
    logic [PW-1:0] pxl_q;

    logic [PW-1:0] bank0_q [256];
    logic [PW-1:0] bank1_q [256];

    logic [7:0]    rd_addr;
    logic [PW-1:0] rd_data;
    logic          clearing;
    logic          draw_busy;

    logic          bank_we   [2];
    logic [7:0]    bank_addr [2];
    logic [PW-1:0] bank_data [2];

    // hdump[8] is beyond the 256-pixel line and DLY is fixed at 1.
    logic unused_bits;
    assign unused_bits = ^{hdump[8], DLY == 1};

    assign rd_addr   = flip ? ~hdump[7:0] : hdump[7:0];
    assign rd_data   = sel_q ? bank1_q[rd_addr] : bank0_q[rd_addr];
    assign clearing  = rst || (state_q == CLR);
    assign draw_busy = (state_q == DRAW);

    // Each bank has a single write port. The read bank only ever sees the
    // clear-after-read write and the write bank only the drawer, so the two
    // sides never meet in one bank. During a swap clk sel_q still holds the
    // old value, so a coincident drawer write lands in the pre-swap bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            // NOTE: every output gets a default first so no path leaves a
            // latch behind.
            bank_we[b]   = 1'b0;
            bank_addr[b] = cnt_q;
            bank_data[b] = '0;
            if (clearing) begin
                bank_we[b] = 1'b1;
            end else if (sel_q == b[0]) begin
                bank_we[b]   = pxl_cen && LHBL;
                bank_addr[b] = rd_addr;
            end else begin
                // Zero pixels are transparent and never overwrite.
                bank_we[b]   = drw.wr_en && draw_busy && (|drw.wr_pxl);
                bank_addr[b] = drw.wr_x;
                bank_data[b] = drw.wr_pxl;
            end
        end
    end

    // NOTE: the RAM arrays have no reset branch; the CLR sweep zeroes them,
    // which keeps them mappable to block/distributed RAM.
    always_ff @(posedge clk) begin
        if (bank_we[0]) bank0_q[bank_addr[0]] <= bank_data[0];
        if (bank_we[1]) bank1_q[bank_addr[1]] <= bank_data[1];
    end

    // Control FSM plus the output pixel register. The asynchronous RAM read
    // is sampled here in the same clk that the clear-after-read write
    // happens, so pxl_q gets the value from before the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLR;
            cnt_q        <= 8'd0;
            sel_q        <= 1'b0;
            draw_start_q <= 1'b0;
            overrun_q    <= 1'b0;
            pxl_q        <= '0;
        end else begin
            draw_start_q <= 1'b0;
            case (state_q)
                CLR: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == 8'hFF) state_q <= IDLE;
                end
                IDLE: begin
                    if (hinit) begin
                        sel_q        <= ~sel_q;
                        draw_start_q <= 1'b1;
                        state_q      <= DRAW;
                    end
                end
                DRAW: begin
                    if (hinit) begin
                        // Line ended before the drawer finished: flag it,
                        // swap anyway and start the next line.
                        sel_q        <= ~sel_q;
                        draw_start_q <= 1'b1;
                        overrun_q    <= 1'b1;
                    end else if (drw.draw_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= CLR;
            endcase

            if (state_q == CLR) begin
                pxl_q <= '0;
            end else if (pxl_cen) begin
                pxl_q <= LHBL ? rd_data : '0;
            end
        end
    end

    assign drw.draw_start = draw_start_q;
    assign drw.draw_busy  = draw_busy;
    assign overrun        = overrun_q;
    assign pxl            = pxl_q;

endmodule
